// File: rtl/decode_stage_pkg.sv
// Shared decode constants: MIPS opcode/funct values, ALU control and branch-type
// encodings, and the registered control bundle carried from ID into EX.
package decode_stage_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // jal writes its return address here
    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_LUI  = 4'b1011
    } alu_ctl_e;

    typedef enum logic [2:0] {
        BP_NONE = 3'b000,
        BP_BEQ  = 3'b001,
        BP_BNE  = 3'b010
    } bp_ctl_e;

    // All-zero value of this struct is the NOP bundle
    typedef struct packed {
        logic     regwrite;
        logic     regdst;
        logic     alusrc;
        logic     memwrite;
        logic     memtoreg;
        logic     link;
        bp_ctl_e  bpctl;
        alu_ctl_e aluctl;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// asynchronous clear. $0 is hard-wired to zero and never stored.
// Optional feature macro: DECODE_WB_BYPASS_EN -- when defined, a read of the
// register being written in the same cycle returns the incoming write data.
module decode_stage_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    logic [31:0] r_regs [1:31];

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            // Each register clears on reset and loads when addressed by write-back
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_regs[gi] <= '0;
                else if (i_we && (i_waddr == 5'(gi)))
                    r_regs[gi] <= i_wdata;
            end
        end
    endgenerate

    // Read mux: $0 returns zero; optionally forward a same-cycle write
    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        if (i_raddr_a != 5'd0) begin
`ifdef DECODE_WB_BYPASS_EN
            if (i_we && (i_waddr == i_raddr_a))
                o_rdata_a = i_wdata;
            else
                o_rdata_a = r_regs[i_raddr_a];
`else
            o_rdata_a = r_regs[i_raddr_a];
`endif
        end
        if (i_raddr_b != 5'd0) begin
`ifdef DECODE_WB_BYPASS_EN
            if (i_we && (i_waddr == i_raddr_b))
                o_rdata_b = i_wdata;
            else
                o_rdata_b = r_regs[i_raddr_b];
`else
            o_rdata_b = r_regs[i_raddr_b];
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: decodes the fetched word, reads the register
// file, accepts memory-stage write-back and registers the ID bundle for execute.
// Jump redirect to fetch is combinational. Optional feature macro:
// DECODE_WB_BYPASS_EN (same-cycle write-back forwarding inside the register file).
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        AnyStall,
    input  logic [31:0] FetchData_IF,
    input  logic        RegWrite_ME,
    input  logic        MemToReg_ME,
    input  logic [31:0] RdDat_ME,
    input  logic [31:0] Result_ME,
    input  logic [4:0]  WriteReg_ME,
    output logic        Jump_ID,
    output logic [25:0] JumpTgt_ID,
    output logic        RegWrite_ID,
    output logic        RegDst_ID,
    output logic        AluSrc_ID,
    output logic        MemWrite_ID,
    output logic        MemToReg_ID,
    output logic        Link_ID,
    output logic [2:0]  BpCtl_ID,
    output logic [3:0]  AluControl_ID,
    output logic [31:0] SignImm_ID,
    output logic [15:0] Imm_ID,
    output logic [4:0]  Rt_ID,
    output logic [4:0]  Rd_ID,
    output logic [31:0] RdDatA_ID,
    output logic [31:0] RdDatB_ID
);
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_wb_data;
    logic [31:0] w_rdat_a;
    logic [31:0] w_rdat_b;
    ctrl_t       w_ctrl;
    logic        w_zero_ext;
    logic [4:0]  w_rd;
    logic [31:0] w_sign_imm;

    ctrl_t       r_ctrl;
    logic [31:0] r_sign_imm;
    logic [15:0] r_imm;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [31:0] r_rdat_a;
    logic [31:0] r_rdat_b;

    assign w_op      = FetchData_IF[31:26];
    assign w_funct   = FetchData_IF[5:0];
    assign w_imm     = FetchData_IF[15:0];
    assign w_wb_data = MemToReg_ME ? RdDat_ME : Result_ME;

    // Fetch redirect must be seen before the next edge, so it bypasses the ID flops
    assign Jump_ID    = (w_op == OP_J) || (w_op == OP_JAL);
    assign JumpTgt_ID = FetchData_IF[25:0];

    decode_stage_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (RegWrite_ME),
        .i_waddr   (WriteReg_ME),
        .i_wdata   (w_wb_data),
        .i_raddr_a (FetchData_IF[25:21]),
        .i_raddr_b (FetchData_IF[20:16]),
        .o_rdata_a (w_rdat_a),
        .o_rdata_b (w_rdat_b)
    );

    // Opcode/funct decode into the control bundle; anything unrecognised is a NOP
    always_comb begin
        w_ctrl     = '0;
        w_zero_ext = 1'b0;
        w_rd       = FetchData_IF[15:11];
        case (w_op)
            OP_RTYPE: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = 1'b1;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_ctrl.aluctl = ALU_ADD;
                    FN_SUB, FN_SUBU: w_ctrl.aluctl = ALU_SUB;
                    FN_AND:          w_ctrl.aluctl = ALU_AND;
                    FN_OR:           w_ctrl.aluctl = ALU_OR;
                    FN_XOR:          w_ctrl.aluctl = ALU_XOR;
                    FN_NOR:          w_ctrl.aluctl = ALU_NOR;
                    FN_SLT:          w_ctrl.aluctl = ALU_SLT;
                    FN_SLTU:         w_ctrl.aluctl = ALU_SLTU;
                    FN_SLL:          w_ctrl.aluctl = ALU_SLL;
                    FN_SRL:          w_ctrl.aluctl = ALU_SRL;
                    FN_SRA:          w_ctrl.aluctl = ALU_SRA;
                    default:         w_ctrl        = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                case (w_op)
                    OP_SLTI:  w_ctrl.aluctl = ALU_SLT;
                    OP_SLTIU: w_ctrl.aluctl = ALU_SLTU;
                    OP_ANDI:  w_ctrl.aluctl = ALU_AND;
                    OP_ORI:   w_ctrl.aluctl = ALU_OR;
                    OP_XORI:  w_ctrl.aluctl = ALU_XOR;
                    OP_LUI:   w_ctrl.aluctl = ALU_LUI;
                    default:  w_ctrl.aluctl = ALU_ADD;
                endcase
                w_zero_ext = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI);
            end
            OP_LW: begin
                w_ctrl.aluctl   = ALU_ADD;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.memtoreg = 1'b1;
            end
            OP_SW: begin
                w_ctrl.aluctl   = ALU_ADD;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.aluctl = ALU_SUB;
                w_ctrl.bpctl  = BP_BEQ;
            end
            OP_BNE: begin
                w_ctrl.aluctl = ALU_SUB;
                w_ctrl.bpctl  = BP_BNE;
            end
            OP_JAL: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = 1'b1;
                w_ctrl.link     = 1'b1;
                w_rd            = LINK_REG;
            end
            default: ;
        endcase
    end

    assign w_sign_imm = w_zero_ext ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};

    // ID pipeline flops: clear to the NOP bundle on reset, hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_sign_imm <= '0;
            r_imm      <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_rdat_a   <= '0;
            r_rdat_b   <= '0;
        end else if (!AnyStall) begin
            r_ctrl     <= w_ctrl;
            r_sign_imm <= w_sign_imm;
            r_imm      <= w_imm;
            r_rt       <= FetchData_IF[20:16];
            r_rd       <= w_rd;
            r_rdat_a   <= w_rdat_a;
            r_rdat_b   <= w_rdat_b;
        end
    end

    assign RegWrite_ID   = r_ctrl.regwrite;
    assign RegDst_ID     = r_ctrl.regdst;
    assign AluSrc_ID     = r_ctrl.alusrc;
    assign MemWrite_ID   = r_ctrl.memwrite;
    assign MemToReg_ID   = r_ctrl.memtoreg;
    assign Link_ID       = r_ctrl.link;
    assign BpCtl_ID      = r_ctrl.bpctl;
    assign AluControl_ID = r_ctrl.aluctl;
    assign SignImm_ID    = r_sign_imm;
    assign Imm_ID        = r_imm;
    assign Rt_ID         = r_rt;
    assign Rd_ID         = r_rd;
    assign RdDatA_ID     = r_rdat_a;
    assign RdDatB_ID     = r_rdat_b;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by randomized
// instructions/write-backs/stalls checked against a behavioural model.
// Honours DECODE_WB_BYPASS_EN for the same-cycle read-during-write expectation.
module tb_decode_stage;

    typedef struct packed {
        logic        rw;
        logic        rdst;
        logic        asrc;
        logic        mw;
        logic        mtr;
        logic        lk;
        logic [2:0]  bp;
        logic [3:0]  alu;
        logic [31:0] simm;
        logic [15:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        AnyStall;
    logic [31:0] FetchData_IF;
    logic        RegWrite_ME;
    logic        MemToReg_ME;
    logic [31:0] RdDat_ME;
    logic [31:0] Result_ME;
    logic [4:0]  WriteReg_ME;
    logic        Jump_ID;
    logic [25:0] JumpTgt_ID;
    logic        RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID, Link_ID;
    logic [2:0]  BpCtl_ID;
    logic [3:0]  AluControl_ID;
    logic [31:0] SignImm_ID;
    logic [15:0] Imm_ID;
    logic [4:0]  Rt_ID, Rd_ID;
    logic [31:0] RdDatA_ID, RdDatB_ID;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_rf [32];
    bundle_t     exp_b;
    bundle_t     obs_b;

    logic [5:0] op_tab [17] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fn_tab [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .AnyStall      (AnyStall),
        .FetchData_IF  (FetchData_IF),
        .RegWrite_ME   (RegWrite_ME),
        .MemToReg_ME   (MemToReg_ME),
        .RdDat_ME      (RdDat_ME),
        .Result_ME     (Result_ME),
        .WriteReg_ME   (WriteReg_ME),
        .Jump_ID       (Jump_ID),
        .JumpTgt_ID    (JumpTgt_ID),
        .RegWrite_ID   (RegWrite_ID),
        .RegDst_ID     (RegDst_ID),
        .AluSrc_ID     (AluSrc_ID),
        .MemWrite_ID   (MemWrite_ID),
        .MemToReg_ID   (MemToReg_ID),
        .Link_ID       (Link_ID),
        .BpCtl_ID      (BpCtl_ID),
        .AluControl_ID (AluControl_ID),
        .SignImm_ID    (SignImm_ID),
        .Imm_ID        (Imm_ID),
        .Rt_ID         (Rt_ID),
        .Rd_ID         (Rd_ID),
        .RdDatA_ID     (RdDatA_ID),
        .RdDatB_ID     (RdDatB_ID)
    );

    assign obs_b = {RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID, Link_ID,
                    BpCtl_ID, AluControl_ID, SignImm_ID, Imm_ID, Rt_ID, Rd_ID,
                    RdDatA_ID, RdDatB_ID};

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural decode: instruction classes from the ISA tables
    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b);
        bundle_t    d;
        logic [5:0] op;
        logic [5:0] fn;
        int         alu;
        op = ins[31:26];
        fn = ins[5:0];
        d = '0;
        d.imm = ins[15:0];
        d.rt  = ins[20:16];
        d.rd  = ins[15:11];
        d.a   = a;
        d.b   = b;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
            d.simm = {16'h0, ins[15:0]};
        else
            d.simm = {{16{ins[15]}}, ins[15:0]};
        alu = -1;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: alu = 2;
                6'h22, 6'h23: alu = 6;
                6'h24: alu = 0;
                6'h25: alu = 1;
                6'h26: alu = 3;
                6'h27: alu = 4;
                6'h2A: alu = 7;
                6'h2B: alu = 8;
                6'h00: alu = 5;
                6'h02: alu = 9;
                6'h03: alu = 10;
                default: alu = -1;
            endcase
            if (alu >= 0) begin
                d.rw = 1; d.rdst = 1; d.alu = 4'(alu);
            end
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            case (op)
                6'h0A: alu = 7;
                6'h0B: alu = 8;
                6'h0C: alu = 0;
                6'h0D: alu = 1;
                6'h0E: alu = 3;
                6'h0F: alu = 11;
                default: alu = 2;
            endcase
            d.rw = 1; d.asrc = 1; d.alu = 4'(alu);
        end else if (op == 6'h23) begin
            d.alu = 4'd2; d.rw = 1; d.asrc = 1; d.mtr = 1;
        end else if (op == 6'h2B) begin
            d.alu = 4'd2; d.asrc = 1; d.mw = 1;
        end else if (op == 6'h04 || op == 6'h05) begin
            d.alu = 4'd6; d.bp = (op == 6'h04) ? 3'd1 : 3'd2;
        end else if (op == 6'h03) begin
            d.rw = 1; d.rdst = 1; d.lk = 1; d.rd = 5'd31;
        end
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] widx, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && widx == idx) return wd;
`endif
        return model_rf[idx];
    endfunction

    // One cycle: drive at negedge, check jump outputs combinationally,
    // then check the registered bundle just after the rising edge.
    task automatic step(input logic [31:0] ins, input logic stall, input logic we,
                        input logic [4:0] widx, input logic mtr, input logic [31:0] rdd,
                        input logic [31:0] res);
        logic [31:0] wd;
        logic        is_j;
        @(negedge clk);
        FetchData_IF = ins;
        AnyStall     = stall;
        RegWrite_ME  = we;
        WriteReg_ME  = widx;
        MemToReg_ME  = mtr;
        RdDat_ME     = rdd;
        Result_ME    = res;
        wd = mtr ? rdd : res;
        #1;
        is_j = (ins[31:26] == 6'h02) || (ins[31:26] == 6'h03);
        chk("jump", Jump_ID, is_j);
        chk("jtgt", JumpTgt_ID, ins[25:0]);
        if (!stall)
            exp_b = model_decode(ins, model_read(ins[25:21], we, widx, wd),
                                 model_read(ins[20:16], we, widx, wd));
        @(posedge clk);
        if (we && widx != 5'd0) model_rf[widx] = wd;
        #1;
        $display("step ins=%08h stall=%0b wb=%0b/$%0d=%08h", ins, stall, we, widx, wd);
        chk("bundle", obs_b, exp_b);
    endtask

    task automatic do_reset(input logic stall);
        @(negedge clk);
        reset    = 1'b1;
        AnyStall = stall;
        #1;
        chk("reset_async", obs_b, '0);
        @(posedge clk);
        #1;
        chk("reset_hold", obs_b, '0);
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        exp_b = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        reset        = 1'b1;
        AnyStall     = 1'b0;
        FetchData_IF = '0;
        RegWrite_ME  = 1'b0;
        MemToReg_ME  = 1'b0;
        RdDat_ME     = '0;
        Result_ME    = '0;
        WriteReg_ME  = '0;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        exp_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs_b, '0);
        @(negedge clk);
        reset = 1'b0;

        // Registers read zero after reset
        step({6'h00, 5'd7, 5'd9, 5'd3, 5'd0, 6'h20}, 0, 0, 0, 0, 0, 0);
        chk("rst_rdA", RdDatA_ID, 32'h0);
        chk("rst_rdB", RdDatB_ID, 32'h0);

        // Write-back $5, then add $3,$5,$5
        step(32'hFC00_0000, 0, 1, 5'd5, 0, 32'hDEAD_BEEF, 32'h1234);
        chk("nop_ctl", {RegWrite_ID, RegDst_ID, AluSrc_ID}, 3'b000);
        step({6'h00, 5'd5, 5'd5, 5'd3, 5'd0, 6'h20}, 0, 0, 0, 0, 0, 0);
        chk("add_rdA", RdDatA_ID, 32'h1234);
        chk("add_rdB", RdDatB_ID, 32'h1234);
        chk("add_alu", AluControl_ID, 4'b0010);
        chk("add_rdst", RegDst_ID, 1'b1);
        chk("add_rd", Rd_ID, 5'd3);

        // Write to $0 is discarded
        step(32'hFC00_0000, 0, 1, 5'd0, 1, 32'hFFFF_FFFF, 0);
        step({6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20}, 0, 0, 0, 0, 0, 0);
        chk("r0_rdA", RdDatA_ID, 32'h0);

        // Zero- vs sign-extension
        step({6'h0D, 5'd0, 5'd2, 16'h8001}, 0, 0, 0, 0, 0, 0);
        chk("ori_simm", SignImm_ID, 32'h0000_8001);
        step({6'h08, 5'd0, 5'd2, 16'h8001}, 0, 0, 0, 0, 0, 0);
        chk("addi_simm", SignImm_ID, 32'hFFFF_8001);
        chk("addi_asrc", AluSrc_ID, 1'b1);

        // jal: redirect is combinational, link bundle follows the edge
        @(negedge clk);
        FetchData_IF = {6'h03, 26'h000_0040};
        #1;
        chk("jal_jump", Jump_ID, 1'b1);
        chk("jal_tgt", JumpTgt_ID, 26'h40);
        step({6'h03, 26'h000_0040}, 0, 0, 0, 0, 0, 0);
        chk("jal_link", Link_ID, 1'b1);
        chk("jal_rd", Rd_ID, 5'd31);

        // Stall holds lw bundle while fetch presents sw
        step({6'h23, 5'd5, 5'd6, 16'h0010}, 0, 0, 0, 0, 0, 0);
        step({6'h2B, 5'd5, 5'd6, 16'h0020}, 1, 0, 0, 0, 0, 0);
        step({6'h2B, 5'd5, 5'd6, 16'h0020}, 1, 1, 5'd6, 0, 0, 32'h55);
        chk("stall_mtr", MemToReg_ID, 1'b1);
        chk("stall_mw", MemWrite_ID, 1'b0);
        step({6'h2B, 5'd5, 5'd6, 16'h0020}, 0, 0, 0, 0, 0, 0);
        chk("unstall_mw", MemWrite_ID, 1'b1);
        chk("unstall_rdB", RdDatB_ID, 32'h55);

        // Same-cycle write and read of $7
        step({6'h00, 5'd7, 5'd0, 5'd1, 5'd0, 6'h25}, 0, 1, 5'd7, 0, 0, 32'hA5A5_0001);
        step({6'h00, 5'd7, 5'd0, 5'd1, 5'd0, 6'h25}, 0, 0, 0, 0, 0, 0);
        chk("wb_visible", RdDatA_ID, 32'hA5A5_0001);

        // Reset while stalled wins and clears the register file
        step({6'h00, 5'd7, 5'd5, 5'd1, 5'd0, 6'h22}, 1, 0, 0, 0, 0, 0);
        do_reset(1'b1);
        step({6'h00, 5'd7, 5'd5, 5'd1, 5'd0, 6'h22}, 0, 0, 0, 0, 0, 0);
        chk("rst_clr_A", RdDatA_ID, 32'h0);
        chk("rst_clr_B", RdDatB_ID, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            op  = op_tab[$urandom_range(0, 16)];
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 7) != 0) ins[31:26] = op;
            if (ins[31:26] == 6'h00 && $urandom_range(0, 5) != 0)
                ins[5:0] = fn_tab[$urandom_range(0, 12)];
            step(ins, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline, between fetch and execute. Decodes the 32-bit instruction word from fetch and owns the 32×32 register file. Accepts write-back from the memory stage and registers control, immediates and operands into ID pipeline flops for execute. Also produces the unregistered jump redirect consumed by fetch.

## Interface
- No parameters.
- clk  in  1  clock; all flops rise-edge.
- reset  in  1  asynchronous, active-high.
- AnyStall  in  1  hold all ID pipeline flops.
- FetchData_IF  in  32  instruction from fetch.
- RegWrite_ME  in  1  write-back enable.
- MemToReg_ME  in  1  write-back select: 1 = RdDat_ME, 0 = Result_ME.
- RdDat_ME  in  32  load data.
- Result_ME  in  32  ALU result.
- WriteReg_ME  in  5  write-back register index.
- Jump_ID  out  1  combinational; FetchData_IF is j/jal.
- JumpTgt_ID  out  26  combinational; FetchData_IF[25:0].
- RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID, Link_ID  out  1 each  registered controls.
- BpCtl_ID  out  3  branch type: 000 none, 001 beq, 010 bne.
- AluControl_ID  out  4  ALU op.
- SignImm_ID  out  32  extended immediate.
- Imm_ID  out  16  raw instr[15:0].
- Rt_ID, Rd_ID  out  5  register indices.
- RdDatA_ID, RdDatB_ID  out  32  rs/rt read data.

## Operation
- R-type (op 0x00), funct → AluControl: 0x20/0x21 ADD 0010, 0x22/0x23 SUB 0110, 0x24 AND 0000, 0x25 OR 0001, 0x26 XOR 0011, 0x27 NOR 0100, 0x2A SLT 0111, 0x2B SLTU 1000, 0x00 SLL 0101, 0x02 SRL 1001, 0x03 SRA 1010.
- R-type controls: RegWrite=1, RegDst=1.
- I-type: addi/addiu ADD, slti SLT, sltiu SLTU, andi AND, ori OR, xori XOR, lui LUI 1011. Each sets RegWrite=1, AluSrc=1.
- lw (0x23): ADD, RegWrite, AluSrc, MemToReg.
- sw (0x2B): ADD, AluSrc, MemWrite.
- beq (0x04) / bne (0x05): SUB, BpCtl 001 / 010.
- j (0x02): Jump=1.
- jal (0x03): Jump=1, Link=1, RegWrite=1, RegDst=1, Rd_ID forced to 31.
- Unknown opcode or funct: all controls 0 (NOP).
- SignImm: zero-extended for andi/ori/xori, sign-extended otherwise.
- Register file reads: rs=instr[25:21], rt=instr[20:16]. $0 reads 0.
- Write-back: data = MemToReg_ME ? RdDat_ME : Result_ME. Written at WriteReg_ME when RegWrite_ME=1 and index≠0.
- Write-back is never gated by AnyStall.

## Timing
- ID flops load each edge unless AnyStall=1, in which case they hold.
- One-cycle latency: FetchData_IF at edge N appears on ID outputs after edge N.
- Jump_ID / JumpTgt_ID are combinational, so fetch redirects at the next edge.
- Reset: all ID outputs 0 (NOP bundle). All 32 registers cleared to 0.
- Reset mid-stall: reset wins.
- Simultaneous write and read of the same register: see Configuration.

## Configuration
- DECODE_WB_BYPASS_EN defined: a read of an index being written the same cycle (nonzero, RegWrite_ME=1) returns the write-back data.
- DECODE_WB_BYPASS_EN undefined: such a read returns the old register contents. The new value is visible from the next cycle.

## Structure
- Shared package holds:
  - opcode and funct constants
  - AluControl encodings
  - BpCtl encodings
- One sub-module: regfile (32×32, two combinational read ports, one synchronous write port, async reset, optional bypass).
- Decoder and ID flops live in decode_stage.

## Test plan
- Reset, then idle → all ID outputs 0; read of any register = 0.
- Write-back RegWrite_ME=1, WriteReg_ME=5, MemToReg_ME=0, Result_ME=0x1234; next cycle issue add $3,$5,$5 → RdDatA/B=0x1234, AluControl=0010, RegDst=1, Rd_ID=3.
- Write-back to $0 with 0xFFFF_FFFF → subsequent read of $0 = 0.
- ori $2,$0,0x8001 → SignImm=0x0000_8001. addi $2,$0,0x8001 → SignImm=0xFFFF_8001, AluSrc=1.
- jal 0x0000040 → Jump_ID=1 and JumpTgt_ID=0x40 in the same cycle; next cycle Link=1, Rd_ID=31.
- AnyStall=1 while the instruction changes from lw to sw → ID outputs keep the lw bundle (MemToReg=1) until AnyStall drops.
